// File: rtl/carrd_issue_ctrl.sv
// In-order issue stage for the vector units: a small instruction FIFO in front of a
// per-unit busy tracker and an LMUL-group-aware vector-register pending-write scoreboard.
module carrd_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 4,
  parameter int UNIT_W    = 2
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [UNIT_W-1:0]        in_unit,
  input  logic [4:0]               in_vd,
  input  logic [4:0]               in_vs1,
  input  logic [4:0]               in_vs2,
  input  logic                     in_use_vs1,
  input  logic                     in_use_vs2,
  input  logic                     in_wr_vd,
  input  logic [1:0]               in_lmul,
  input  logic                     flush,
  input  logic [NUM_UNITS-1:0]     unit_done,
  output logic                     issue_valid,
  output logic [31:0]              issue_instr,
  output logic [UNIT_W-1:0]        issue_unit,
  output logic [NUM_UNITS-1:0]     unit_busy,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]       instr;
    logic [UNIT_W-1:0] unit;
    logic [4:0]        vd;
    logic [4:0]        vs1;
    logic [4:0]        vs2;
    logic              use_vs1;
    logic              use_vs2;
    logic              wr_vd;
    logic [1:0]        lmul;
  } entry_t;

  // Register group covered by (base, lmul); indices wrap past v31 back to v0.
  function automatic logic [31:0] grp_mask(input logic [4:0] base, input logic [1:0] lmul);
    logic [31:0] m;
    logic [2:0]  g;
    m = '0;
    unique case (lmul)
      2'd0:    g = 3'd1;
      2'd1:    g = 3'd2;
      default: g = 3'd4;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < g) m[base + 5'(i)] = 1'b1;
    end
    return m;
  endfunction

  entry_t                 fifo_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [NUM_UNITS-1:0]   busy_q, busy_d;
  logic [31:0]            pending_q, pending_d;
  logic [31:0]            wmask_q [NUM_UNITS];
  logic [31:0]            wmask_d [NUM_UNITS];

  entry_t      in_entry;
  entry_t      head;
  logic        push;
  logic        pop;
  logic        head_present;
  logic        unit_free;
  logic        vs1_hz;
  logic        vs2_hz;
  logic        vd_hz;
  logic        issue_ok;
  logic [31:0] vd_mask;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;

  always_comb begin
    in_entry = '{instr: in_instr, unit: in_unit, vd: in_vd, vs1: in_vs1, vs2: in_vs2,
                 use_vs1: in_use_vs1, use_vs2: in_use_vs2, wr_vd: in_wr_vd, lmul: in_lmul};
  end

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign head     = fifo_q[rd_ptr_q];

  // Issue decision looks only at registered state: occupancy, busy flags, pending bitmap.
  assign head_present = (count_q != '0);
  assign unit_free    = ~busy_q[head.unit];
  assign vd_mask      = grp_mask(head.vd, head.lmul);
  assign vs1_hz       = head.use_vs1 & (|(grp_mask(head.vs1, head.lmul) & pending_q));
  assign vs2_hz       = head.use_vs2 & (|(grp_mask(head.vs2, head.lmul) & pending_q));
  assign vd_hz        = head.wr_vd   & (|(vd_mask & pending_q));
  assign issue_ok     = head_present & unit_free & ~vs1_hz & ~vs2_hz & ~vd_hz;
  assign pop          = issue_ok;

  assign issue_valid = issue_ok;
  assign issue_instr = issue_ok ? head.instr : '0;
  assign issue_unit  = issue_ok ? head.unit  : '0;
  assign unit_busy   = busy_q;
  assign pending     = pending_q;
  assign count       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Completions clear first, then the issuing unit's bits are set, so a set always wins.
  always_comb begin
    busy_d   = busy_q;
    clr_mask = '0;
    set_mask = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      wmask_d[u] = wmask_q[u];
      if (unit_done[u] && busy_q[u]) begin
        busy_d[u]  = 1'b0;
        clr_mask   = clr_mask | wmask_q[u];
        wmask_d[u] = '0;
      end
    end
    if (issue_ok) begin
      busy_d[head.unit] = 1'b1;
      if (head.wr_vd) begin
        set_mask           = vd_mask;
        wmask_d[head.unit] = vd_mask;
      end else begin
        wmask_d[head.unit] = '0;
      end
    end
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      pending_q <= '0;
      for (int u = 0; u < NUM_UNITS; u++) wmask_q[u] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      for (int u = 0; u < NUM_UNITS; u++) wmask_q[u] <= wmask_d[u];
    end
  end

endmodule

// File: tb/tb_carrd_issue_ctrl.sv
// Bench for carrd_issue_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based behavioural model of the issue stage.
module tb_carrd_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int NU    = 4;

  logic        clk;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [1:0]  in_unit;
  logic [4:0]  in_vd, in_vs1, in_vs2;
  logic        in_use_vs1, in_use_vs2, in_wr_vd;
  logic [1:0]  in_lmul;
  logic        flush;
  logic [3:0]  unit_done;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [1:0]  issue_unit;
  logic [3:0]  unit_busy;
  logic [31:0] pending;
  logic [2:0]  count;

  carrd_issue_ctrl #(.DEPTH(DEPTH), .NUM_UNITS(NU), .UNIT_W(2)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_unit(in_unit), .in_vd(in_vd), .in_vs1(in_vs1),
    .in_vs2(in_vs2), .in_use_vs1(in_use_vs1), .in_use_vs2(in_use_vs2),
    .in_wr_vd(in_wr_vd), .in_lmul(in_lmul), .flush(flush), .unit_done(unit_done),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_unit(issue_unit),
    .unit_busy(unit_busy), .pending(pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: queue of waiting instructions, busy flag and owned registers per unit.
  typedef struct {
    logic [31:0] instr;
    int unit, vd, vs1, vs2, lmul;
    bit u1, u2, wr;
  } ent_t;

  ent_t        mq[$];
  bit          mbusy[NU];
  bit [31:0]   mown[NU];
  bit [31:0]   mpend;

  function automatic int gsize(input int lmul);
    return (lmul == 0) ? 1 : (lmul == 1) ? 2 : 4;
  endfunction

  function automatic bit any_pending(input int base, input int lmul);
    for (int k = 0; k < gsize(lmul); k++)
      if (mpend[(base + k) % 32]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit can_issue(input ent_t e);
    if (mbusy[e.unit]) return 1'b0;
    if (e.u1 && any_pending(e.vs1, e.lmul)) return 1'b0;
    if (e.u2 && any_pending(e.vs2, e.lmul)) return 1'b0;
    if (e.wr && any_pending(e.vd, e.lmul)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [3:0] busy_vec();
    bit [3:0] b;
    for (int u = 0; u < NU; u++) b[u] = mbusy[u];
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpend = '0;
    for (int u = 0; u < NU; u++) begin
      mbusy[u] = 1'b0;
      mown[u]  = '0;
    end
  endtask

  task automatic idle();
    nrst = 1'b0; in_valid = 1'b0; flush = 1'b0; unit_done = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    bit   exp_iss;
    ent_t h;
    ent_t n;
    @(negedge clk);
    exp_iss = (mq.size() > 0) && can_issue(mq[0]);
    if (mq.size() > 0) h = mq[0];
    chk("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < DEPTH)});
    chk("count", {29'd0, count}, 32'(mq.size()));
    chk("issue_valid", {31'd0, issue_valid}, {31'd0, exp_iss});
    chk("issue_instr", issue_instr, exp_iss ? h.instr : 32'd0);
    chk("issue_unit", {30'd0, issue_unit}, exp_iss ? 32'(h.unit) : 32'd0);
    chk("unit_busy", {28'd0, unit_busy}, {28'd0, busy_vec()});
    chk("pending", pending, mpend);
    if (nrst) begin
      model_reset();
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (unit_done[u] && mbusy[u]) begin
          mbusy[u] = 1'b0;
          for (int r = 0; r < 32; r++) if (mown[u][r]) mpend[r] = 1'b0;
          mown[u] = '0;
        end
      end
      if (exp_iss) begin
        void'(mq.pop_front());
        mbusy[h.unit] = 1'b1;
        mown[h.unit]  = '0;
        if (h.wr) begin
          for (int k = 0; k < gsize(h.lmul); k++) begin
            mpend[(h.vd + k) % 32]        = 1'b1;
            mown[h.unit][(h.vd + k) % 32] = 1'b1;
          end
        end
      end
      if (flush) begin
        mq.delete();
      end else if (in_valid && (mq.size() + (exp_iss ? 1 : 0)) < DEPTH) begin
        n.instr = in_instr; n.unit = int'(in_unit); n.vd = int'(in_vd);
        n.vs1 = int'(in_vs1); n.vs2 = int'(in_vs2); n.lmul = int'(in_lmul);
        n.u1 = in_use_vs1; n.u2 = in_use_vs2; n.wr = in_wr_vd;
        mq.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unit, input int vd, input int vs1, input int vs2,
                      input bit u1, input bit u2, input bit wr, input int lmul);
    idle();
    in_valid = 1'b1; in_instr = $urandom; in_unit = 2'(unit);
    in_vd = 5'(vd); in_vs1 = 5'(vs1); in_vs2 = 5'(vs2);
    in_use_vs1 = u1; in_use_vs2 = u2; in_wr_vd = wr; in_lmul = 2'(lmul);
    tick();
    idle();
  endtask

  task automatic done(input logic [3:0] d);
    idle();
    unit_done = d;
    tick();
    idle();
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r < 6) ? 5'(r) : 5'(r + 23);
  endfunction

  initial begin
    idle();
    in_instr = '0; in_unit = '0; in_vd = '0; in_vs1 = '0; in_vs2 = '0;
    in_use_vs1 = 1'b0; in_use_vs2 = 1'b0; in_wr_vd = 1'b0; in_lmul = '0;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    idle();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    tick();

    // Basic ALU issue and completion.
    push(0, 3, 1, 2, 1, 1, 1, 0);
    tick();
    chk("basic_pend", pending, 32'h0000_0008);
    chk("basic_busy", {28'd0, unit_busy}, 32'h1);
    done(4'b0001);
    chk("basic_pend_clr", pending, 32'd0);
    chk("basic_busy_clr", {28'd0, unit_busy}, 32'd0);

    // RAW: SLDU reads v5 which sits in the ALU's v4..v5 group.
    push(0, 4, 0, 0, 0, 0, 1, 1);
    push(2, 0, 0, 5, 0, 1, 0, 1);
    chk("raw_pend", pending, 32'h0000_0030);
    repeat (3) tick();
    done(4'b0001);
    chk("raw_pend_clr", pending, 32'd0);
    tick();
    chk("raw_sldu_busy", {28'd0, unit_busy}, 32'h4);
    done(4'b0100);

    // Wrap-around group v31,v0 blocks a later reader of v0.
    push(0, 31, 0, 0, 0, 0, 1, 1);
    tick();
    chk("wrap_pend", pending, 32'h8000_0001);
    push(1, 9, 0, 0, 1, 0, 0, 0);
    repeat (2) tick();
    done(4'b0001);
    chk("wrap_busy", {28'd0, unit_busy}, 32'd0);
    tick();
    done(4'b0010);

    // Structural: second RED waits for the first to complete.
    push(1, 8, 0, 0, 0, 0, 1, 0);
    push(1, 10, 0, 0, 0, 0, 1, 0);
    repeat (2) tick();
    done(4'b0010);
    chk("struct_wait", {31'd0, issue_valid}, 32'd1);
    tick();
    done(4'b0010);

    // Full FIFO behind a busy lanes unit, then flush.
    push(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < DEPTH + 1; i++) push(0, 0, 0, 0, 0, 0, 0, 0);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    idle();
    flush = 1'b1; in_valid = 1'b1;
    tick();
    idle();
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_busy", {28'd0, unit_busy}, 32'h1);
    done(4'b0001);

    // Reset with an operation outstanding; a late completion must do nothing.
    push(3, 7, 0, 0, 0, 0, 1, 2);
    tick();
    push(0, 1, 0, 0, 0, 0, 1, 0);
    idle();
    nrst = 1'b1;
    tick();
    idle();
    chk("mid_rst_pend", pending, 32'd0);
    chk("mid_rst_busy", {28'd0, unit_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    done(4'b1000);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      nrst       = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 49) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      in_instr   = $urandom;
      in_unit    = 2'($urandom_range(0, 3));
      in_vd      = pick_reg();
      in_vs1     = pick_reg();
      in_vs2     = pick_reg();
      in_use_vs1 = 1'($urandom_range(0, 1));
      in_use_vs2 = 1'($urandom_range(0, 1));
      in_wr_vd   = ($urandom_range(0, 3) != 0);
      in_lmul    = 2'($urandom_range(0, 3));
      for (int u = 0; u < NU; u++) unit_done[u] = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
